// File: rtl/multi_dac_iface_pkg.sv
// Shared definitions for the multi-lane SPI DAC serialiser: sequencer word layout and FSM states.
package multi_dac_iface_pkg;

    localparam int unsigned LANE_MSB   = 31;
    localparam int unsigned LANE_LSB   = 25;
    localparam int unsigned COMMIT_BIT = 24;
    localparam int unsigned LANE_W     = LANE_MSB - LANE_LSB + 1;

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic              commit;
        logic [23:0]       payload;
    } dac_word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LDAC  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

endpackage

// File: rtl/multi_dac_iface_tick.sv
// Half-period tick generator: down-counter reloaded with the divider value sampled at frame start.
module multi_dac_iface_tick
    import multi_dac_iface_pkg::*;
#(
    parameter int unsigned DIVW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_en,
    input  logic [DIVW-1:0] i_div,
    output logic            o_tick_c
);

    logic [DIVW-1:0] r_h;
    logic [DIVW-1:0] r_cnt;

    // Load captures H-1 for the whole frame; the counter wraps back to it on every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_h   <= i_div;
            r_cnt <= i_div;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? r_h : r_cnt - DIVW'(1);
        end
    end

    assign o_tick_c = i_en & (r_cnt == '0);

endmodule

// File: rtl/multi_dac_iface.sv
// NCH-lane double-buffered SPI DAC serialiser with shared SCLK and LDAC#.
// Build option: MULTI_DAC_LDAC_PULSE_EN enables the LDAC# pulse state; otherwise dac_ldacn_o is tied low.
module multi_dac_iface
    import multi_dac_iface_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned DW   = 24,
    parameter int unsigned DIVW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     data_i,
    input  logic            valid_i,
    input  logic [DIVW-1:0] spi_clk_div_i,
    output logic            busy_o,
    output logic            overflow_o,
    output logic            dac_sclk_o,
    output logic [NCH-1:0]  dac_syncn_o,
    output logic [NCH-1:0]  dac_sdo_o,
    output logic            dac_ldacn_o
);

    localparam int unsigned BCW = $clog2(DW + 1);

    dac_word_t        w_word;
    logic             w_commit;
    state_e           r_state, w_state_nxt;
    logic             r_sclk_lo, w_sclk_lo_nxt;
    logic [BCW-1:0]   r_bit, w_bit_nxt;
    logic             r_queued, w_queued_nxt;
    logic             r_overflow, w_overflow_nxt;
    logic [NCH-1:0]   r_pend, w_pend_wr, w_pend_nxt;
    logic [NCH-1:0]   r_act, w_act_nxt;
    logic [NCH-1:0]   w_wr;
    logic             w_start, w_adv, w_tick;
    logic             w_frame_sel, w_sclk_nxt, w_busy_nxt;
    logic [DW-1:0]    r_hold [NCH];
    logic [DW-1:0]    r_shift[NCH];
    logic [DW-1:0]    w_hold_nxt [NCH];
    logic [DW-1:0]    w_shift_nxt[NCH];
    logic [NCH-1:0]   w_sdo_nxt, w_syncn_nxt;
    logic             r_busy, r_sclk;
    logic [NCH-1:0]   r_syncn, r_sdo;

    assign w_word   = dac_word_t'(data_i);
    assign w_commit = valid_i & w_word.commit;

    multi_dac_iface_tick #(.DIVW(DIVW)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_start),
        .i_en     (r_state != ST_IDLE),
        .i_div    (spi_clk_div_i),
        .o_tick_c (w_tick)
    );

    // Per-lane holding and shift registers; shift regs only change on frame start or SCLK rise.
    for (genvar g = 0; g < NCH; g++) begin : g_lane
        assign w_wr[g]        = valid_i && (w_word.lane == LANE_W'(g));
        assign w_hold_nxt[g]  = w_wr[g] ? w_word.payload[DW-1:0] : r_hold[g];
        assign w_shift_nxt[g] = w_start ? w_hold_nxt[g] :
                                w_adv   ? {r_shift[g][DW-2:0], 1'b0} : r_shift[g];
        assign w_sdo_nxt[g]   = w_frame_sel & w_act_nxt[g] & w_shift_nxt[g][DW-1];
        assign w_syncn_nxt[g] = ~(w_frame_sel & w_act_nxt[g]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hold[g]  <= '0;
                r_shift[g] <= '0;
            end else begin
                r_hold[g]  <= w_hold_nxt[g];
                r_shift[g] <= w_shift_nxt[g];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sclk_lo_nxt  = r_sclk_lo;
        w_bit_nxt      = r_bit;
        w_queued_nxt   = r_queued;
        w_overflow_nxt = r_overflow;
        w_start        = 1'b0;
        w_adv          = 1'b0;
        w_pend_wr      = r_pend | w_wr;

        case (r_state)
            ST_IDLE: begin
                if (w_commit && (|w_pend_wr)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_state_nxt   = ST_SHIFT;
                    w_sclk_lo_nxt = 1'b1;
                    w_bit_nxt     = '0;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (r_sclk_lo) begin
                        w_sclk_lo_nxt = 1'b0;
                        w_adv         = 1'b1;
                    end else if (r_bit == BCW'(DW - 1)) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_bit_nxt     = r_bit + BCW'(1);
                        w_sclk_lo_nxt = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
`ifdef MULTI_DAC_LDAC_PULSE_EN
                    w_state_nxt = ST_LDAC;
`else
                    w_state_nxt = ST_GAP;
`endif
                end
            end
            ST_LDAC: begin
                if (w_tick) w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (w_tick) begin
                    if ((r_queued || w_commit) && (|w_pend_wr)) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A restart out of GAP consumes the queued commit; a same-cycle commit queues behind it.
        if ((r_state == ST_GAP) && w_tick) begin
            w_queued_nxt = w_start && r_queued && w_commit;
        end else if (w_commit && (r_state != ST_IDLE)) begin
            if (r_queued) w_overflow_nxt = 1'b1;
            else          w_queued_nxt   = 1'b1;
        end

        w_pend_nxt  = w_start ? '0 : w_pend_wr;
        w_act_nxt   = w_start ? w_pend_wr : r_act;
        w_frame_sel = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT);
        w_sclk_nxt  = !((w_state_nxt == ST_SHIFT) && w_sclk_lo_nxt);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sclk_lo  <= 1'b0;
            r_bit      <= '0;
            r_queued   <= 1'b0;
            r_overflow <= 1'b0;
            r_pend     <= '0;
            r_act      <= '0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b1;
            r_syncn    <= '1;
            r_sdo      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sclk_lo  <= w_sclk_lo_nxt;
            r_bit      <= w_bit_nxt;
            r_queued   <= w_queued_nxt;
            r_overflow <= w_overflow_nxt;
            r_pend     <= w_pend_nxt;
            r_act      <= w_act_nxt;
            r_busy     <= w_busy_nxt;
            r_sclk     <= w_sclk_nxt;
            r_syncn    <= w_syncn_nxt;
            r_sdo      <= w_sdo_nxt;
        end
    end

`ifdef MULTI_DAC_LDAC_PULSE_EN
    logic r_ldacn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ldacn <= 1'b1;
        else        r_ldacn <= (w_state_nxt != ST_LDAC);
    end

    assign dac_ldacn_o = r_ldacn;
`else
    assign dac_ldacn_o = 1'b0;
`endif

    assign busy_o      = r_busy;
    assign overflow_o  = r_overflow;
    assign dac_sclk_o  = r_sclk;
    assign dac_syncn_o = r_syncn;
    assign dac_sdo_o   = r_sdo;

endmodule
